psec_instr_sequencer: RTL and testbench
=======================================

// Module: psec_instr_sequencer
// PURPOSE
//  Executes commands written over SPI to the instruction reg (addr 2), using trigger_channel_mask (addr 1) and mode (addr 3).
//  Sits in iclk domain between SPI register block and acquisition/readout core: arms triggering, holds, then
//  walks hit channels through a req/ack readout engine. Status byte returns to SPI as a read-only register.
// PARAMETERS
//  NUM_CH          8     channels; equals trigger_channel_mask width
//  SYNC_STAGES     2     flops in instr_tgl synchronizer (>=2)
//  HOLD_CYCLES     16    iclk cycles in HOLD before readout (>=1)
//  TIMEOUT_CYCLES  1024  max iclk cycles waiting for rd_ack_i per channel
// PORTS
//  iclk         in   1       internal clock; all state on rising edge
//  rstn         in   1       reset, synchronous, active-low
//  instr_tgl    in   1       SPI domain; toggles once per completed write to addr 2
//  instruction  in   8       opcode; quasi-static, stable before instr_tgl toggles
//  trig_mask    in   NUM_CH  trigger_channel_mask; quasi-static while ARMED
//  mode         in   8       [0] auto_rearm, [1] read_all (read full mask, not just hits); others ignored
//  trig_in      in   NUM_CH  per-channel trigger, synchronous to iclk, level
//  rd_ack_i     in   1       readout engine done with rd_ch_o; 1-cycle pulse
//  arm_o        out  1       acquisition armed
//  rd_req_o     out  1       readout request; held until rd_ack_i
//  rd_ch_o      out  3       channel index for rd_req_o ($clog2(NUM_CH))
//  done_o       out  1       readout sequence complete
//  status_o     out  8       [2:0] state, [3] err_badcmd, [4] err_timeout, [7:5] event count mod 8
// BEHAVIOUR
//  Reset (rstn=0 at edge): state IDLE; all outputs 0; errors, counters, hit vector cleared. Mid-operation
//   reset drops rd_req_o/arm_o on that edge; a pending instr_tgl edge is discarded (sync flops cleared).
//  Command capture: instr_tgl through SYNC_STAGES flops, XOR with prior stage -> cmd_stb (1 cycle);
//   instruction sampled on cmd_stb. Latency toggle->action = SYNC_STAGES+1 cycles.
//  Opcodes: 00 NOP, 01 ARM, 02 SOFT_TRIG, 03 ABORT, 04 CLEAR; any other -> no action, err_badcmd=1.
//  States: IDLE=0, ARMED=1, HOLD=2, READOUT=3, DONE=4 (registered outputs, 1 cycle after transition).
//  IDLE: ARM with trig_mask!=0 -> ARMED; ARM with trig_mask==0 -> stay, err_badcmd=1.
//  ARMED: arm_o=1. |(trig_in&trig_mask) -> HOLD, hit=trig_in&trig_mask. SOFT_TRIG -> HOLD, hit=trig_mask.
//   Both same cycle: hit=trig_mask. Event count +1 (wraps 7->0) on entry to HOLD.
//  HOLD: arm_o=0; counter runs HOLD_CYCLES, then READOUT. If mode[1], hit replaced by trig_mask on entry.
//  READOUT: rd_ch_o=index of lowest set bit of hit; rd_req_o=1. On rd_ack_i: clear that bit, rd_req_o=0
//   for exactly one cycle, then next bit; hit==0 after clear -> DONE. Timeout counter reset per channel;
//   reaching TIMEOUT_CYCLES sets err_timeout, drops rd_req_o, -> DONE (remaining channels skipped).
//   rd_ack_i while rd_req_o=0 is ignored.
//  DONE: done_o=1. mode[0]=1 -> ARMED next cycle (done_o high exactly 1 cycle). Else wait: ARM -> ARMED,
//   CLEAR -> IDLE.
//  ABORT in any state -> IDLE next edge; arm_o/rd_req_o/done_o cleared; errors kept.
//  CLEAR in any state -> IDLE, also clears err_badcmd, err_timeout, event count.
//  ARM/SOFT_TRIG received in a state not listed above: ignored, no error.
//  cmd_stb has priority over trig_in/rd_ack_i/timeout in the same cycle.
// STRUCTURE
//  Package psec_seq_pkg: opcode enum (seq_op_e), state enum (seq_state_e, 3 bits), status bit position
//   localparams, lowest-set-bit function.
//  Sub-module psec_toggle_sync: SYNC_STAGES synchronizer + edge detect producing cmd_stb; rest is one FSM.
// TESTING
//  ARM (mask=0x05), trig_in=0x04 -> HOLD; after 16 cycles rd_req_o=1, rd_ch_o=2; ack -> done_o=1, status[2:0]=4.
//  mask=0x81, SOFT_TRIG -> reads ch0 then ch7 with one idle rd_req_o cycle between; event count=1.
//  mode=0x03, mask=0x06, trig_in=0x02 -> reads ch1, ch2 (read_all); DONE 1 cycle then arm_o=1 again.
//  No rd_ack_i for 1024 cycles on ch3 -> err_timeout=1, rd_req_o=0, DONE; CLEAR -> status_o=0x00.
//  Opcode 0x7F -> err_badcmd=1, state unchanged; ARM with mask=0 -> err_badcmd=1, stays IDLE.
//  ABORT during READOUT, and rstn=0 mid-HOLD -> next edge rd_req_o=0, arm_o=0, state IDLE; toggle latency=3.

Source files
------------

// File: rtl/psec_seq_pkg.sv
// Shared types and helpers for the pSec instruction sequencer.
// Opcode and state encodings match the values software sees over SPI.
package psec_seq_pkg;

    typedef enum logic [7:0] {
        OpNop      = 8'h00,
        OpArm      = 8'h01,
        OpSoftTrig = 8'h02,
        OpAbort    = 8'h03,
        OpClear    = 8'h04
    } seq_op_e;

    typedef enum logic [2:0] {
        SeqIdle    = 3'd0,
        SeqArmed   = 3'd1,
        SeqHold    = 3'd2,
        SeqReadout = 3'd3,
        SeqDone    = 3'd4
    } seq_state_e;

    localparam int unsigned StatErrBadcmd  = 3;
    localparam int unsigned StatErrTimeout = 4;
    localparam int unsigned StatEvtLsb     = 5;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [4:0] lowest_set_bit(input logic [31:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/psec_toggle_sync.sv
// Brings the SPI-domain command toggle into iclk and turns each level change into
// a single-cycle strobe.
module psec_toggle_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic iclk,
    input  logic rstn,
    input  logic tgl_i,
    output logic stb_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], tgl_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge iclk) begin
        if (!rstn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign stb_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/psec_instr_sequencer.sv
// Command-driven trigger/readout sequencer: arms on SPI command, holds after a hit,
// then walks the hit channels through a req/ack readout engine.
module psec_instr_sequencer
    import psec_seq_pkg::*;
#(
    parameter int unsigned NUM_CH         = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned ChW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              iclk,
    input  logic              rstn,
    input  logic              instr_tgl,
    input  logic [7:0]        instruction,
    input  logic [NUM_CH-1:0] trig_mask,
    input  logic [7:0]        mode,
    input  logic [NUM_CH-1:0] trig_in,
    input  logic              rd_ack_i,
    output logic              arm_o,
    output logic              rd_req_o,
    output logic [ChW-1:0]    rd_ch_o,
    output logic              done_o,
    output logic [7:0]        status_o
);

    localparam logic [2:0] StIdle    = SeqIdle;
    localparam logic [2:0] StArmed   = SeqArmed;
    localparam logic [2:0] StHold    = SeqHold;
    localparam logic [2:0] StReadout = SeqReadout;
    localparam logic [2:0] StDone    = SeqDone;

    localparam int unsigned HoldW = $clog2(HOLD_CYCLES) + 1;
    localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES) + 1;

    logic              cmd_stb;
    logic [2:0]        state_q, state_d;
    logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [ToW-1:0]    to_cnt_q, to_cnt_d;
    logic [NUM_CH-1:0] hit_q, hit_d, trig_hit;
    logic [2:0]        evt_q, evt_d;
    logic              err_bad_q, err_bad_d, err_to_q, err_to_d;
    logic              arm_q, arm_d, rd_req_q, rd_req_d, done_q, done_d;
    logic [ChW-1:0]    rd_ch_q, rd_ch_d;
    logic              unused_mode;

    assign unused_mode = ^mode[7:2];

    psec_toggle_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_toggle_sync (
        .iclk (iclk),
        .rstn (rstn),
        .tgl_i(instr_tgl),
        .stb_o(cmd_stb)
    );

    assign trig_hit = trig_in & trig_mask;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        to_cnt_d   = to_cnt_q;
        hit_d      = hit_q;
        evt_d      = evt_q;
        err_bad_d  = err_bad_q;
        err_to_d   = err_to_q;
        rd_req_d   = rd_req_q;
        rd_ch_d    = rd_ch_q;

        case (state_q)
            StIdle: ;
            StArmed: begin
                if (|trig_hit) begin
                    state_d    = StHold;
                    hit_d      = trig_hit;
                    hold_cnt_d = '0;
                    evt_d      = evt_q + 3'd1;
                end
            end
            StHold: begin
                if (mode[1]) hit_d = trig_mask;
                if (hold_cnt_q == HoldW'(HOLD_CYCLES - 1)) begin
                    if (hit_d == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d  = StReadout;
                        rd_req_d = 1'b1;
                        rd_ch_d  = ChW'(lowest_set_bit(32'(hit_d)));
                        to_cnt_d = '0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HoldW'(1);
                end
            end
            StReadout: begin
                if (rd_req_q) begin
                    if (rd_ack_i) begin
                        hit_d    = hit_q & ~(NUM_CH'(1) << rd_ch_q);
                        rd_req_d = 1'b0;
                        if (hit_d == '0) state_d = StDone;
                    end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
                        err_to_d = 1'b1;
                        rd_req_d = 1'b0;
                        state_d  = StDone;
                    end else begin
                        to_cnt_d = to_cnt_q + ToW'(1);
                    end
                end else if (hit_q != '0) begin
                    // One idle cycle has elapsed since the last ack: issue the next channel.
                    rd_req_d = 1'b1;
                    rd_ch_d  = ChW'(lowest_set_bit(32'(hit_q)));
                    to_cnt_d = '0;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (mode[0]) state_d = StArmed;
            end
            default: state_d = StIdle;
        endcase

        // Commands override whatever the state logic decided this cycle.
        if (cmd_stb) begin
            case (instruction)
                OpNop: ;
                OpArm: begin
                    if (state_q == StIdle) begin
                        if (|trig_mask) state_d = StArmed;
                        else            err_bad_d = 1'b1;
                    end else if (state_q == StDone) begin
                        state_d = StArmed;
                    end
                end
                OpSoftTrig: begin
                    if (state_q == StArmed) begin
                        state_d    = StHold;
                        hit_d      = trig_mask;
                        hold_cnt_d = '0;
                        evt_d      = evt_q + 3'd1;
                    end
                end
                OpAbort: begin
                    state_d  = StIdle;
                    hit_d    = '0;
                    evt_d    = evt_q;
                    err_to_d = err_to_q;
                end
                OpClear: begin
                    state_d   = StIdle;
                    hit_d     = '0;
                    evt_d     = '0;
                    err_bad_d = 1'b0;
                    err_to_d  = 1'b0;
                end
                default: err_bad_d = 1'b1;
            endcase
        end

        if (state_d != StReadout) rd_req_d = 1'b0;
        arm_d  = (state_d == StArmed);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge iclk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            to_cnt_q   <= '0;
            hit_q      <= '0;
            evt_q      <= '0;
            err_bad_q  <= 1'b0;
            err_to_q   <= 1'b0;
            arm_q      <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_ch_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            to_cnt_q   <= to_cnt_d;
            hit_q      <= hit_d;
            evt_q      <= evt_d;
            err_bad_q  <= err_bad_d;
            err_to_q   <= err_to_d;
            arm_q      <= arm_d;
            rd_req_q   <= rd_req_d;
            rd_ch_q    <= rd_ch_d;
            done_q     <= done_d;
        end
    end

    assign arm_o    = arm_q;
    assign rd_req_o = rd_req_q;
    assign rd_ch_o  = rd_ch_q;
    assign done_o   = done_q;

    always_comb begin
        status_o                     = '0;
        status_o[2:0]                = state_q;
        status_o[StatErrBadcmd]      = err_bad_q;
        status_o[StatErrTimeout]     = err_to_q;
        status_o[StatEvtLsb +: 3]    = evt_q;
    end

endmodule

// File: tb/tb_psec_instr_sequencer.sv
// Directed bench for psec_instr_sequencer with hand-computed expectations.
module tb_psec_instr_sequencer;

    localparam logic [7:0] CNop  = 8'h00;
    localparam logic [7:0] CArm  = 8'h01;
    localparam logic [7:0] CSoft = 8'h02;
    localparam logic [7:0] CAbrt = 8'h03;
    localparam logic [7:0] CClr  = 8'h04;
    localparam logic [7:0] CBad  = 8'h7F;

    logic       iclk = 1'b0;
    logic       rstn = 1'b0;
    logic       instr_tgl = 1'b0;
    logic [7:0] instruction = 8'h00;
    logic [7:0] trig_mask = 8'h00;
    logic [7:0] mode = 8'h00;
    logic [7:0] trig_in = 8'h00;
    logic       rd_ack_i = 1'b0;
    logic       arm_o, rd_req_o, done_o;
    logic [2:0] rd_ch_o;
    logic [7:0] status_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 iclk = ~iclk;

    psec_instr_sequencer dut (
        .iclk       (iclk),
        .rstn       (rstn),
        .instr_tgl  (instr_tgl),
        .instruction(instruction),
        .trig_mask  (trig_mask),
        .mode       (mode),
        .trig_in    (trig_in),
        .rd_ack_i   (rd_ack_i),
        .arm_o      (arm_o),
        .rd_req_o   (rd_req_o),
        .rd_ch_o    (rd_ch_o),
        .done_o     (done_o),
        .status_o   (status_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge iclk);
    endtask

    // Command takes effect on the third rising edge after the toggle.
    task automatic send_cmd(input logic [7:0] op);
        instruction = op;
        instr_tgl   = ~instr_tgl;
        tick(3);
    endtask

    task automatic ack_pulse();
        rd_ack_i = 1'b1;
        tick(1);
        rd_ack_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        check_val("reset_status", 32'(status_o), 32'h00);
        check_val("reset_outs", {arm_o, rd_req_o, done_o}, 3'b000);
        rstn = 1'b1;
        tick(2);

        // Basic trigger path plus toggle latency.
        trig_mask   = 8'h05;
        instruction = CArm;
        instr_tgl   = ~instr_tgl;
        tick(2);
        check_val("lat_before", 32'(status_o[2:0]), 32'd0);
        tick(1);
        check_val("lat_armed", 32'(status_o[2:0]), 32'd1);
        check_val("lat_arm_o", 32'(arm_o), 32'd1);
        trig_in = 8'h04;
        tick(1);
        trig_in = 8'h00;
        check_val("t1_hold", 32'(status_o), 32'h22);
        check_val("t1_arm_low", 32'(arm_o), 32'd0);
        tick(15);
        check_val("t1_hold_end", {status_o[2:0], rd_req_o}, {3'd2, 1'b0});
        tick(1);
        check_val("t1_req", {rd_req_o, rd_ch_o}, {1'b1, 3'd2});
        ack_pulse();
        check_val("t1_done", {done_o, rd_req_o, status_o}, {1'b1, 1'b0, 8'h24});
        tick(3);
        check_val("t1_done_wait", {done_o, status_o[2:0]}, {1'b1, 3'd4});

        // Soft trigger, two channels with an idle gap; late ack in the gap is ignored.
        send_cmd(CClr);
        check_val("t2_clear", 32'(status_o), 32'h00);
        trig_mask = 8'h81;
        send_cmd(CArm);
        send_cmd(CSoft);
        check_val("t2_hold", 32'(status_o), 32'h22);
        tick(16);
        check_val("t2_req0", {rd_req_o, rd_ch_o}, {1'b1, 3'd0});
        ack_pulse();
        check_val("t2_gap", {rd_req_o, status_o[2:0]}, {1'b0, 3'd3});
        ack_pulse();
        check_val("t2_req7", {rd_req_o, rd_ch_o}, {1'b1, 3'd7});
        tick(1);
        check_val("t2_req7_held", 32'(rd_req_o), 32'd1);
        ack_pulse();
        check_val("t2_done", {done_o, status_o}, {1'b1, 8'h24});

        // read_all + auto_rearm.
        send_cmd(CClr);
        mode      = 8'h03;
        trig_mask = 8'h06;
        send_cmd(CArm);
        trig_in = 8'h02;
        tick(1);
        trig_in = 8'h00;
        check_val("t3_hold", 32'(status_o), 32'h22);
        tick(16);
        check_val("t3_req1", {rd_req_o, rd_ch_o}, {1'b1, 3'd1});
        ack_pulse();
        tick(1);
        check_val("t3_req2", {rd_req_o, rd_ch_o}, {1'b1, 3'd2});
        ack_pulse();
        check_val("t3_done", {done_o, arm_o, status_o[2:0]}, {1'b1, 1'b0, 3'd4});
        tick(1);
        check_val("t3_rearm", {done_o, arm_o, status_o[2:0]}, {1'b0, 1'b1, 3'd1});
        mode = 8'h00;
        send_cmd(CClr);

        // Readout timeout on channel 3.
        trig_mask = 8'h08;
        send_cmd(CArm);
        send_cmd(CSoft);
        tick(16);
        check_val("t4_req3", {rd_req_o, rd_ch_o}, {1'b1, 3'd3});
        tick(1023);
        check_val("t4_pre_to", 32'(rd_req_o), 32'd1);
        tick(1);
        check_val("t4_timeout", {rd_req_o, done_o, status_o}, {1'b0, 1'b1, 8'h34});
        send_cmd(CClr);
        check_val("t4_clear", 32'(status_o), 32'h00);

        // Bad opcode and ARM with an empty mask.
        send_cmd(CBad);
        check_val("t5_badop", 32'(status_o), 32'h08);
        send_cmd(CClr);
        trig_mask = 8'h00;
        send_cmd(CArm);
        check_val("t5_arm_mask0", {arm_o, status_o}, {1'b0, 8'h08});
        send_cmd(CClr);

        // ABORT during READOUT keeps errors and event count.
        trig_mask = 8'h03;
        send_cmd(CArm);
        send_cmd(CBad);
        check_val("t6_bad_armed", 32'(status_o), 32'h09);
        send_cmd(CSoft);
        check_val("t6_hold", 32'(status_o), 32'h2A);
        tick(16);
        check_val("t6_req0", {rd_req_o, rd_ch_o}, {1'b1, 3'd0});
        instruction = CAbrt;
        instr_tgl   = ~instr_tgl;
        tick(2);
        check_val("t6_abort_lat", 32'(rd_req_o), 32'd1);
        tick(1);
        check_val("t6_abort", {rd_req_o, arm_o, done_o, status_o}, {3'b000, 8'h28});

        // Reset in the middle of HOLD.
        send_cmd(CClr);
        trig_mask = 8'h01;
        send_cmd(CArm);
        send_cmd(CSoft);
        tick(5);
        check_val("t7_in_hold", 32'(status_o[2:0]), 32'd2);
        instruction = CNop;
        rstn = 1'b0;
        tick(1);
        check_val("t7_reset", {rd_req_o, arm_o, done_o, status_o}, {3'b000, 8'h00});
        rstn = 1'b1;
        tick(20);
        check_val("t7_after", {rd_req_o, status_o}, {1'b0, 8'h00});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
